// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and default operand widths.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DEF_N_W = 16;
    localparam int DEF_D_W = 8;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude if it fits, emit the quotient bit.
module div_restore_step #(
    parameter int D_W = 8
) (
    input  logic [D_W-1:0] rem_i,
    input  logic [D_W-1:0] dmag_i,
    input  logic           bit_i,
    output logic [D_W-1:0] rem_o,
    output logic           q_o
);

    logic [D_W:0] shifted;
    logic [D_W:0] diff;
    logic         unused_msb;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dmag_i};
    assign q_o     = (shifted >= {1'b0, dmag_i});
    // Both results are below the divisor magnitude, so the top bit is always zero.
    assign rem_o   = q_o ? diff[D_W-1:0] : shifted[D_W-1:0];
    assign unused_msb = ^{diff[D_W], shifted[D_W]};

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: sign/magnitude split on accept, N_W-cycle unsigned
// restoring division, sign fix-up, then a valid/ready result hold.
module seq_signed_divider
    import seq_div_pkg::*;
#(
    parameter int N_W = DEF_N_W,
    parameter int D_W = DEF_D_W
) (
    input  logic           clk,
    input  logic           rst_n,
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds valid and data steady until that edge.
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_zero,
    output logic           overflow,
    output div_state_e     dbg_state_o
);

    localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam logic [N_W-1:0] N_MIN = {1'b1, {(N_W-1){1'b0}}};

    div_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] a_q, a_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic [D_W-1:0] dmag_q, dmag_d;
    logic           sn_q, sn_d;
    logic           sd_q, sd_d;
    logic [N_W-1:0] quotient_q, quotient_d;
    logic [D_W-1:0] remainder_q, remainder_d;
    logic           div_zero_q, div_zero_d;
    logic           overflow_q, overflow_d;

    logic [D_W-1:0] step_rem;
    logic           step_q;

    div_restore_step #(
        .D_W (D_W)
    ) u_step (
        .rem_i  (rem_q),
        .dmag_i (dmag_q),
        .bit_i  (a_q[N_W-1]),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            rem_q       <= '0;
            dmag_q      <= '0;
            sn_q        <= 1'b0;
            sd_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            rem_q       <= rem_d;
            dmag_q      <= dmag_d;
            sn_q        <= sn_d;
            sd_q        <= sd_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        rem_d       = rem_q;
        dmag_d      = dmag_q;
        sn_d        = sn_q;
        sd_d        = sd_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sn_d   = dividend[N_W-1];
                    sd_d   = divisor[D_W-1];
                    a_d    = dividend[N_W-1] ? -dividend : dividend;
                    dmag_d = divisor[D_W-1] ? -divisor : divisor;
                    rem_d  = '0;
                    cnt_d  = CNT_W'(N_W - 1);
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                        overflow_d  = 1'b0;
                        state_d     = DONE;
                    end else if (dividend == N_MIN && divisor == '1) begin
                        quotient_d  = N_MIN;
                        remainder_d = '0;
                        div_zero_d  = 1'b0;
                        overflow_d  = 1'b1;
                        state_d     = DONE;
                    end else begin
                        div_zero_d = 1'b0;
                        overflow_d = 1'b0;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                // a_q shifts dividend bits out of the top and quotient bits in at the bottom.
                a_d   = {a_q[N_W-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = (sn_q ^ sd_q) ? -a_q : a_q;
                remainder_d = sn_q ? -rem_q : rem_q;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_zero    = div_zero_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: hand-computed quotients/remainders,
// latency, zero/overflow flags, output hold under back-pressure and mid-op reset.
module tb_seq_signed_divider;
    import seq_div_pkg::*;

    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int RW  = N_W + D_W + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N_W-1:0] dividend = '0;
    logic [D_W-1:0] divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_zero;
    logic           overflow;
    div_state_e     dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];

    seq_signed_divider #(
        .N_W (N_W),
        .D_W (D_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .overflow    (overflow),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Driver: present operands at a falling edge, wait for in_ready, accept on the rising edge.
    task automatic accept_op(input logic [N_W-1:0] a, input logic [D_W-1:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts the accept edge as cycle 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic collect(input string tag);
        logic [RW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".q"}, {16'd0, quotient}, {16'd0, e[RW-1 -: N_W]});
        check({tag, ".r"}, {24'd0, remainder}, {24'd0, e[D_W+1:2]});
        check({tag, ".dz"}, {31'd0, div_zero}, {31'd0, e[1]});
        check({tag, ".ov"}, {31'd0, overflow}, {31'd0, e[0]});
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                          input logic [N_W-1:0] eq, input logic [D_W-1:0] er,
                          input logic edz, input logic eov, input int elat);
        int lat;
        exp_q.push_back({eq, er, edz, eov});
        accept_op(a, b);
        wait_result(lat);
        check({tag, ".lat"}, lat, elat);
        collect(tag);
    endtask

    initial begin
        int lat;
        int seen;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.state", {30'd0, dbg_state}, {30'd0, IDLE});
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.q", {16'd0, quotient}, 32'd0);
        check("rst.r", {24'd0, remainder}, 32'd0);
        check("rst.dz", {31'd0, div_zero}, 32'd0);
        check("rst.ov", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);

        run_op("p100_7",   16'd100,   8'd7,    16'd14,     8'd2,    1'b0, 1'b0, 18);
        run_op("n100_7",   16'hFF9C,  8'd7,    16'hFFF2,   8'hFE,   1'b0, 1'b0, 18);
        run_op("p100_n7",  16'd100,   8'hF9,   16'hFFF2,   8'd2,    1'b0, 1'b0, 18);
        run_op("n7_n2",    16'hFFF9,  8'hFE,   16'd3,      8'hFF,   1'b0, 1'b0, 18);
        run_op("max_127",  16'h7FFF,  8'd127,  16'd258,    8'd1,    1'b0, 1'b0, 18);
        run_op("p1000_m",  16'd1000,  8'h80,   16'hFFF9,   8'd104,  1'b0, 1'b0, 18);
        run_op("min_1",    16'h8000,  8'd1,    16'h8000,   8'd0,    1'b0, 1'b0, 18);
        run_op("min_m",    16'h8000,  8'h80,   16'd256,    8'd0,    1'b0, 1'b0, 18);
        run_op("div0",     16'd5,     8'd0,    16'hFFFF,   8'd0,    1'b1, 1'b0, 1);
        run_op("ovf",      16'h8000,  8'hFF,   16'h8000,   8'd0,    1'b0, 1'b1, 1);

        // Back-pressure: result holds and new operands are ignored while in DONE.
        exp_q.push_back({16'd14, 8'd2, 1'b0, 1'b0});
        accept_op(16'd100, 8'd7);
        wait_result(lat);
        check("hold.lat", lat, 18);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 16'd3;
            divisor  = 8'd1;
            @(posedge clk);
            #1;
            check("hold.valid", {31'd0, out_valid}, 32'd1);
            check("hold.q", {16'd0, quotient}, 32'd14);
            check("hold.r", {24'd0, remainder}, 32'd2);
            check("hold.in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        collect("hold");
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("hold.no_spurious", seen, 0);

        // Reset during CALC cycle 5 aborts with no result.
        accept_op(16'd1000, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        check("abort.in_calc", {30'd0, dbg_state}, {30'd0, CALC});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort.state", {30'd0, dbg_state}, {30'd0, IDLE});
        check("abort.valid", {31'd0, out_valid}, 32'd0);
        check("abort.q", {16'd0, quotient}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort.no_valid", seen, 0);
        run_op("p7_2", 16'd7, 8'd2, 16'd3, 8'd1, 1'b0, 1'b0, 18);

        check("sb.leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 SHALL have parameter N_W, default 16, dividend and quotient width.
REQ-002 SHALL have parameter D_W, default 8, divisor and remainder width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands valid.
REQ-006 SHALL have port in_ready, output, 1, divider can accept operands.
REQ-007 SHALL have port dividend, input, N_W, signed two's-complement dividend.
REQ-008 SHALL have port divisor, input, D_W, signed two's-complement divisor.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port quotient, output, N_W, signed quotient.
REQ-012 SHALL have port remainder, output, D_W, signed remainder.
REQ-013 SHALL have port div_zero, output, 1, divisor was zero; qualified by out_valid.
REQ-014 SHALL have port overflow, output, 1, quotient not representable; qualified by out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL assert in_ready only in IDLE; accept occurs on the edge where in_valid && in_ready.
REQ-017 On accept, SHALL latch the sign of each operand, their N_W/D_W-bit unsigned magnitudes, and the zero/overflow conditions.
REQ-018 On accept with divisor==0, SHALL go IDLE->DONE with quotient=all-ones, remainder=0, div_zero=1, overflow=0.
REQ-019 On accept with dividend==most-negative and divisor==-1, SHALL go IDLE->DONE with quotient=most-negative (0x8000), remainder=0, overflow=1.
REQ-020 Otherwise SHALL go IDLE->CALC and perform unsigned restoring division, one quotient bit per cycle, MSB first, for exactly N_W cycles (4-bit down-counter, wraps to terminal at 0).
REQ-021 CALC step: partial remainder (D_W+1 bits) shifted left with next dividend bit; if >= |divisor|, subtract and set quotient bit to 1, else set it to 0.
REQ-022 After the last CALC cycle, SHALL enter FIX: negate quotient if operand signs differ; negate remainder if dividend negative; then go to DONE.
REQ-023 Result semantics: truncation toward zero; dividend == quotient*divisor + remainder; |remainder| < |divisor|; remainder sign equals dividend sign or remainder is zero.
REQ-024 SHALL assert out_valid only in DONE; quotient, remainder, div_zero, overflow SHALL hold stable while out_valid && !out_ready.
REQ-025 DONE->IDLE on out_ready; in_ready is not asserted in the same cycle (no accept-while-draining).
REQ-026 Latency: normal op out_valid rises N_W+2 cycles after the accept edge (18 at default); zero/overflow cases rise 1 cycle after.
REQ-027 in_valid, dividend, divisor SHALL be ignored outside IDLE.
REQ-028 divisor==most-negative (-128) SHALL be handled correctly via D_W-bit unsigned magnitude 128.

Reset
REQ-029 With rst_n low at a clock edge: state=IDLE, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, counter=0; in_ready=1 from the first edge with rst_n high.
REQ-030 Reset during CALC, FIX or DONE SHALL abort the operation with no out_valid pulse produced.

Structure
REQ-031 Shared package seq_div_pkg SHALL hold the state enum and default N_W/D_W constants.
REQ-032 Single sub-module div_restore_step: combinational one-bit restoring step (partial remainder, divisor magnitude, dividend bit -> next remainder, quotient bit).

Verification
REQ-033 100 / 7 -> quotient 14, remainder 2, flags 0, out_valid 18 cycles after accept.
REQ-034 -100 / 7 -> quotient -14, remainder -2; 100 / -7 -> quotient -14, remainder 2.
REQ-035 5 / 0 -> quotient 0xFFFF, remainder 0, div_zero 1, out_valid 1 cycle after accept.
REQ-036 -32768 / -1 -> quotient 0x8000, overflow 1; -32768 / -128 -> quotient 256, remainder 0.
REQ-037 out_ready held low 10 cycles in DONE -> outputs stable, in_ready 0; new in_valid ignored until DONE->IDLE.
REQ-038 rst_n low at CALC cycle 5 -> IDLE next cycle, no out_valid; subsequent 7 / 2 -> quotient 3, remainder 1.
